zbt_display_reader: RTL
=======================

# zbt_display_reader

Display-side reader for the ZBT frame buffer that the accumulation path fills with 36-bit words, each holding four 8-bit pixels (bits [35:32] unused). It generates read addresses from the VGA raster counters and absorbs the ZBT read latency. It unpacks one pixel per clock and delays the sync and blank signals so they stay aligned with the pixel. It also provides a one-frame clear: after a request, every visible word is zeroed right after it is read, which resets the max-accumulation buffer for the next scan.

## Interface
- READ_LATENCY, 2, clocks from zbt_read_addr to valid zbt_read_data
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- hcount  in  11  raster column
- vcount  in  10  raster line
- hsync, vsync, blank  in  1 each  raw VGA timing
- zbt_read_addr  out  19  {1'b0, vcount, hcount[9:2]}, combinational
- zbt_read_data  in  36  returned word
- zbt_write_addr  out  19  clear-write address
- zbt_write_data  out  36  always 36'h0
- zbt_we  out  1  clear-write strobe, one cycle per word
- clear_req  in  1  one-cycle request to zero the next full frame
- clear_busy  out  1  high in ARMED or CLEARING
- clear_done  out  1  one-cycle pulse when a clear completes
- px_out  out  8  pixel aligned with the delayed syncs
- hsync_out, vsync_out, blank_out  out  1 each  timing delayed by LAT = READ_LATENCY+1

## Operation
- Lane select: pixel lane k = word[8k+7:8k]; lane 0 is hcount[1:0]==0.
- Capture: a delay line of depth READ_LATENCY carries hcount[1:0] and the address. The word is captured when the delayed hcount[1:0]==0. px_out is registered from the captured word, selected by the lane of the current delayed position.
- Blanking: if the delayed hcount >= H_ACTIVE, the delayed vcount >= V_ACTIVE, or the delayed blank is high, px_out = 0.
- Clear FSM:
  - IDLE: on clear_req, go to ARMED.
  - ARMED: on hcount==0 && vcount==0, go to CLEARING.
  - CLEARING: on every capture cycle inside the active region, assert zbt_we with zbt_write_addr equal to the delayed read address and data 0. The word is still displayed normally. After the capture of the last word (delayed vcount==V_ACTIVE-1, delayed hcount[9:2]==H_ACTIVE/4-1), go to IDLE and pulse clear_done.
- clear_req while ARMED or CLEARING is ignored, with no restart.
- clear_req in the same cycle that clear_done pulses is accepted: the FSM goes to ARMED.
- Reset: all delay lines, the captured word, and outputs go to 0 and the FSM goes to IDLE. Reset during CLEARING abandons the clear with no clear_done pulse; words already zeroed stay zero.

## Timing
- Reset values: px_out=0, hsync_out=0, vsync_out=0, blank_out=1, zbt_we=0, zbt_write_addr=0, clear_busy=0, clear_done=0.
- Latency: for a pixel at (hcount, vcount), px_out appears LAT=3 clocks later, in the same cycle as the equally delayed syncs.
- zbt_we goes high exactly READ_LATENCY clocks after the address is issued, in the same cycle the read data is captured, so the read always precedes the write of the same word.
- A clear spans exactly one frame: H_ACTIVE/4 × V_ACTIVE write strobes, 76800 by default.

## Structure
- Shared package: ZBT_ADDR_W=19, ZBT_DATA_W=36, PIX_W=8, the lane-extract helper, and the clear FSM state encoding (IDLE, ARMED, CLEARING). The accumulation writer uses the same address and lane definitions.
- One sub-module, zbt_delay_line: a parameterised-width, parameterised-depth register pipe with async active-low reset. It is instantiated for the timing signals, the lane bits, and the address.

## Test plan
- Lane unpacking: memory model with READ_LATENCY=2 and word at address 0 = 36'h0_44332211. Raster at (0,0) -> px_out sequence 11,22,33,44 on clocks 3–6; hsync_out/vsync_out match the inputs delayed by 3.
- Addressing: vcount=5, hcount=12 -> zbt_read_addr=19'h00503 in the same cycle.
- Blanking: hcount=700 with data 36'hF_FFFFFFFF -> px_out=0 and blank_out high 3 clocks later.
- Clear: pulse clear_req mid-frame -> clear_busy=1, no zbt_we until the next (0,0). The following frame gives exactly 76800 zbt_we pulses with data 0, then a one-cycle clear_done. A read-back frame shows all pixels = 0.
- Reset mid-clear: drive reset_n low after 1000 strobes -> zbt_we=0 and clear_busy=0 immediately, and clear_done never pulses.
- Request collisions: clear_req during CLEARING -> ignored, one clear_done. clear_req coincident with clear_done -> re-arms, and a second clear runs on the next frame.

Source files
------------

// File: rtl/zbt_display_reader_pkg.sv
// Shared ZBT frame-buffer definitions: bus widths, word addressing, pixel
// lane extraction and the clear-sequencer state encoding.
package zbt_display_reader_pkg;

  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {
    CLR_IDLE     = 2'd0,
    CLR_ARMED    = 2'd1,
    CLR_CLEARING = 2'd2
  } clr_state_e;

  // One word holds four horizontally adjacent pixels of one line.
  function automatic logic [ZBT_ADDR_W-1:0] zbt_addr(input logic [9:0] vcount,
                                                    input logic [7:0] word_col);
    return {1'b0, vcount, word_col};
  endfunction

  // Lane k occupies bits [8k+7:8k]; bits [35:32] of a word carry no pixel.
  function automatic logic [PIX_W-1:0] zbt_lane(input logic [4*PIX_W-1:0] payload,
                                                input logic [1:0]         lane);
    return payload[PIX_W*lane +: PIX_W];
  endfunction

endpackage

// File: rtl/zbt_delay_line.sv
// Fixed-depth register pipe with asynchronous active-low reset to zero.
module zbt_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/zbt_display_reader.sv
// Display-side ZBT reader: raster addressing, latency alignment, pixel
// unpacking and a one-frame clear that zeroes each visible word after reading it.
//
// state        | meaning
// CLR_IDLE     | no clear pending
// CLR_ARMED    | clear requested, waiting for raster origin (0,0)
// CLR_CLEARING | zeroing every visible word as it is captured
module zbt_display_reader
  import zbt_display_reader_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  blank,
  output logic [ZBT_ADDR_W-1:0] zbt_read_addr,
  input  logic [ZBT_DATA_W-1:0] zbt_read_data,
  output logic [ZBT_ADDR_W-1:0] zbt_write_addr,
  output logic [ZBT_DATA_W-1:0] zbt_write_data,
  output logic                  zbt_we,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [PIX_W-1:0]      px_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  blank_out
);

  localparam int          TIM_W    = 22;
  localparam logic [10:0] H_LIMIT  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIMIT  = 10'(V_ACTIVE);
  localparam logic [7:0]  LAST_COL = 8'(H_ACTIVE / 4 - 1);
  localparam logic [9:0]  LAST_ROW = 10'(V_ACTIVE - 1);

  logic [TIM_W-1:0]      tim_in, tim_dl;
  logic [1:0]            lane_dl;
  logic [ZBT_ADDR_W-1:0] addr_dl;
  logic                  blank_dl, vsync_dl, hsync_dl;
  logic [9:0]            vcount_dl;
  logic [8:0]            hc_hi_dl;
  logic [10:0]           hcount_dl;
  logic                  capture, active_dl, last_word;
  logic                  unused_hi;

  logic [31:0]      word_q, word_d;
  logic [PIX_W-1:0] px_out_q, px_out_d;
  logic             hsync_out_q, hsync_out_d;
  logic             vsync_out_q, vsync_out_d;
  logic             blank_out_q, blank_out_d;
  logic             clear_done_q, clear_done_d;
  clr_state_e       state_q, state_d;
  logic             we;

  assign zbt_read_addr = zbt_addr(vcount, hcount[9:2]);
  assign tim_in        = {blank, vsync, hsync, vcount, hcount[10:2]};
  assign unused_hi     = ^zbt_read_data[35:32];

  zbt_delay_line #(.WIDTH(TIM_W), .DEPTH(READ_LATENCY)) u_tim_dl (
    .clk(clk), .reset_n(reset_n), .d(tim_in), .q(tim_dl)
  );

  zbt_delay_line #(.WIDTH(2), .DEPTH(READ_LATENCY)) u_lane_dl (
    .clk(clk), .reset_n(reset_n), .d(hcount[1:0]), .q(lane_dl)
  );

  zbt_delay_line #(.WIDTH(ZBT_ADDR_W), .DEPTH(READ_LATENCY)) u_addr_dl (
    .clk(clk), .reset_n(reset_n), .d(zbt_read_addr), .q(addr_dl)
  );

  assign {blank_dl, vsync_dl, hsync_dl, vcount_dl, hc_hi_dl} = tim_dl;
  assign hcount_dl = {hc_hi_dl, lane_dl};
  assign capture   = (lane_dl == 2'd0);
  assign active_dl = (hcount_dl < H_LIMIT) && (vcount_dl < V_LIMIT);
  assign last_word = (vcount_dl == LAST_ROW) && (hc_hi_dl[7:0] == LAST_COL);

  // Lane 0 must come straight from the bus: the word lands in word_q only at this edge.
  always_comb begin
    word_d      = capture ? zbt_read_data[31:0] : word_q;
    px_out_d    = (active_dl && !blank_dl) ? zbt_lane(word_d, lane_dl) : '0;
    hsync_out_d = hsync_dl;
    vsync_out_d = vsync_dl;
    blank_out_d = blank_dl;
  end

  always_comb begin
    state_d      = state_q;
    we           = 1'b0;
    clear_done_d = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clear_req) state_d = CLR_ARMED;
      end
      CLR_ARMED: begin
        if (hcount == 11'd0 && vcount == 10'd0) state_d = CLR_CLEARING;
      end
      CLR_CLEARING: begin
        if (capture && active_dl) begin
          we = 1'b1;
          if (last_word) begin
            state_d      = CLR_IDLE;
            clear_done_d = 1'b1;
          end
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q       <= '0;
      px_out_q     <= '0;
      hsync_out_q  <= 1'b0;
      vsync_out_q  <= 1'b0;
      blank_out_q  <= 1'b1;
      clear_done_q <= 1'b0;
      state_q      <= CLR_IDLE;
    end else begin
      word_q       <= word_d;
      px_out_q     <= px_out_d;
      hsync_out_q  <= hsync_out_d;
      vsync_out_q  <= vsync_out_d;
      blank_out_q  <= blank_out_d;
      clear_done_q <= clear_done_d;
      state_q      <= state_d;
    end
  end

  assign zbt_we         = we;
  assign zbt_write_addr = addr_dl;
  assign zbt_write_data = '0;
  assign clear_busy     = (state_q != CLR_IDLE);
  assign clear_done     = clear_done_q;
  assign px_out         = px_out_q;
  assign hsync_out      = hsync_out_q;
  assign vsync_out      = vsync_out_q;
  assign blank_out      = blank_out_q;

endmodule
